// File: rtl/pio_msg_pkg.sv
// pio_msg_pkg
// Shared definitions for the ARM/FPGA PIO message handshake: default command
// codes, response tags, the requester state encoding and a tag helper.
// Used by the requester, the responder and the bench.
package pio_msg_pkg;

    localparam logic [31:0] REQ_CODE  = 32'h0000_0001;
    localparam logic [31:0] READ_CODE = 32'h0000_0201;
    localparam logic [15:0] ACK_TAG   = 16'h0002;
    localparam logic [15:0] DATA_TAG  = 16'h0003;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ZERO = 16'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 16'd1;
    localparam logic [CNT_W-1:0] CNT_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_HOLD = 3'd2,
        ST_READ = 3'd3,
        ST_FIN  = 3'd4,
        ST_ERR  = 3'd5
    } pio_master_state_t;

    // Upper half of a response word carries the message tag.
    function automatic logic [15:0] pio_tag(input logic [31:0] word);
        return word[31:16];
    endfunction

endpackage

// File: rtl/pio_wait_counter.sv
// pio_wait_counter
// 16-bit saturating cycle counter used for the hold interval and the wait
// timeouts.
// Ports:
//   clock  - rising-edge clock
//   resetn - synchronous active-low reset, clears the count
//   clr    - synchronous clear, wins over en
//   en     - count this cycle
//   limit  - number of cycles that constitutes a hit (>= 1)
//   hit    - high during the limit-th cycle since the last clear
module pio_wait_counter
    import pio_msg_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] count_r;
    logic             hit_s;

    // Count register: clear has priority; parks at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // The count is cleared on the entry edge, so it reads limit-1 during the
    // limit-th cycle spent in the state.
    always_comb begin
        hit_s = (count_r >= (limit - CNT_ONE));
    end

    assign hit = hit_s;

endmodule

// File: rtl/pio_handshake_master.sv
// pio_handshake_master
// Requester-side handshake FSM standing in for the ARM side of the ARM/FPGA
// buffer: REQ_CODE -> wait ack -> idle hold -> READ_CODE -> wait data ->
// capture payload.
// Ports:
//   clock      - rising-edge clock
//   resetn     - synchronous active-low reset
//   start      - begin a transaction (sampled in IDLE only)
//   respPio    - responder output PIO word (tag in [31:16], payload in [15:0])
//   cmdPio     - registered command word to the responder
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse on successful completion
//   timeoutErr - one-cycle pulse when a wait state times out
//   result     - last captured payload
module pio_handshake_master #(
    parameter logic [31:0] REQ_CODE    = pio_msg_pkg::REQ_CODE,
    parameter logic [31:0] READ_CODE   = pio_msg_pkg::READ_CODE,
    parameter logic [15:0] ACK_TAG     = pio_msg_pkg::ACK_TAG,
    parameter logic [15:0] DATA_TAG    = pio_msg_pkg::DATA_TAG,
    parameter int          HOLD_CYCLES = 8,
    parameter int          TIMEOUT     = 1024
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] respPio,
    output logic [31:0] cmdPio,
    output logic        busy,
    output logic        done,
    output logic        timeoutErr,
    output logic [15:0] result
);

    import pio_msg_pkg::*;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);

    pio_master_state_t state_r;
    pio_master_state_t next_s;

    logic [31:0] cmd_r;
    logic [31:0] cmd_next_s;
    logic        busy_r;
    logic        done_r;
    logic        terr_r;
    logic [15:0] result_r;

    logic        clr_s;
    logic        hold_en_s;
    logic        to_en_s;
    logic        hold_hit_s;
    logic        to_hit_s;
    logic        ack_seen_s;
    logic        data_seen_s;
    logic        capture_s;

    // Tag decode of the responder word.
    always_comb begin
        ack_seen_s  = (pio_tag(respPio) == ACK_TAG);
        data_seen_s = (pio_tag(respPio) == DATA_TAG);
    end

    // Next-state logic; an expected tag beats a timeout on the same cycle.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s = ST_REQ;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_seen_s) begin
                    next_s = ST_HOLD;
                end else if (to_hit_s) begin
                    next_s = ST_ERR;
                end else begin
                    next_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (hold_hit_s) begin
                    next_s = ST_READ;
                end else begin
                    next_s = ST_HOLD;
                end
            end
            ST_READ: begin
                if (data_seen_s) begin
                    next_s = ST_FIN;
                end else if (to_hit_s) begin
                    next_s = ST_ERR;
                end else begin
                    next_s = ST_READ;
                end
            end
            ST_FIN:  next_s = ST_IDLE;
            ST_ERR:  next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Counter control: both counters restart on every state change, so each
    // wait is measured from its own entry edge.
    always_comb begin
        clr_s     = (next_s != state_r);
        hold_en_s = (state_r == ST_HOLD);
        to_en_s   = (state_r == ST_REQ) || (state_r == ST_READ);
        capture_s = (state_r == ST_READ) && data_seen_s;
    end

    // Command word for the state being entered, so cmdPio is registered yet
    // lines up with the state.
    always_comb begin
        cmd_next_s = 32'h0000_0000;
        case (next_s)
            ST_REQ:  cmd_next_s = REQ_CODE;
            ST_READ: cmd_next_s = READ_CODE;
            default: cmd_next_s = 32'h0000_0000;
        endcase
    end

    pio_wait_counter u_hold_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clr    (clr_s),
        .en     (hold_en_s),
        .limit  (HOLD_LIM),
        .hit    (hold_hit_s)
    );

    pio_wait_counter u_timeout_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clr    (clr_s),
        .en     (to_en_s),
        .limit  (TO_LIM),
        .hit    (to_hit_s)
    );

    // State and registered outputs; reset suppresses any pending pulse.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r  <= ST_IDLE;
            cmd_r    <= 32'h0000_0000;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            terr_r   <= 1'b0;
            result_r <= 16'h0000;
        end else begin
            state_r  <= next_s;
            cmd_r    <= cmd_next_s;
            busy_r   <= (next_s != ST_IDLE);
            done_r   <= (next_s == ST_FIN);
            terr_r   <= (next_s == ST_ERR);
            if (capture_s) begin
                result_r <= respPio[15:0];
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign cmdPio     = cmd_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign timeoutErr = terr_r;
    assign result     = result_r;

endmodule

// File: tb/tb_pio_handshake_master.sv
// tb_pio_handshake_master
// Directed bench for pio_handshake_master with HOLD_CYCLES=8, TIMEOUT=16.
// The responder is played by the stimulus sequence itself.
module tb_pio_handshake_master;

    import pio_msg_pkg::*;

    localparam int HOLD = 8;
    localparam int TMO  = 16;

    logic        clock   = 1'b0;
    logic        resetn  = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] respPio = 32'h0000_0000;
    logic [31:0] cmdPio;
    logic        busy;
    logic        done;
    logic        timeoutErr;
    logic [15:0] result;

    int n_chk    = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int snap     = 0;

    pio_handshake_master #(
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (TMO)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .respPio    (respPio),
        .cmdPio     (cmdPio),
        .busy       (busy),
        .done       (done),
        .timeoutErr (timeoutErr),
        .result     (result)
    );

    always #5 clock = ~clock;

    // Count done pulses independently of the directed checks.
    always @(posedge clock) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse start in IDLE; REQ_CODE must appear right after that edge.
    task automatic start_req();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_value("req_cmd", cmdPio, REQ_CODE);
        chk_value("req_busy", {31'd0, busy}, 32'd1);
    endtask

    // Ack two cycles into REQ, then walk the hold interval to READ.
    task automatic ack_to_read(input bit repulse);
        tick();
        respPio = {ACK_TAG, 16'h0000};
        tick();
        chk_value("hold_cmd", cmdPio, 32'd0);
        for (int i = 1; i < HOLD; i++) begin
            if (repulse && (i == 1)) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk_value("hold_end_cmd", cmdPio, 32'd0);
        chk_value("hold_busy", {31'd0, busy}, 32'd1);
        tick();
        chk_value("read_cmd", cmdPio, READ_CODE);
    endtask

    // Data tag sampled on the n-th edge after READ entry (ACK lingers before).
    task automatic data_after(input int n, input logic [15:0] payload, input bit repulse);
        for (int i = 1; i < n; i++) begin
            if (repulse && (i == 1)) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk_value("pre_data_cmd", cmdPio, READ_CODE);
        chk_value("pre_data_done", {31'd0, done}, 32'd0);
        chk_value("pre_data_terr", {31'd0, timeoutErr}, 32'd0);
        respPio = {DATA_TAG, payload};
        tick();
        chk_value("fin_done", {31'd0, done}, 32'd1);
        chk_value("fin_result", {16'd0, result}, {16'd0, payload});
        chk_value("fin_cmd", cmdPio, 32'd0);
        chk_value("fin_busy", {31'd0, busy}, 32'd1);
        tick();
        chk_value("idle_done", {31'd0, done}, 32'd0);
        chk_value("idle_busy", {31'd0, busy}, 32'd0);
        chk_value("idle_cmd", cmdPio, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_value("rst_cmd", cmdPio, 32'd0);
        chk_value("rst_busy", {31'd0, busy}, 32'd0);
        chk_value("rst_done", {31'd0, done}, 32'd0);
        chk_value("rst_terr", {31'd0, timeoutErr}, 32'd0);
        chk_value("rst_result", {16'd0, result}, 32'd0);
        resetn = 1'b1;
        tick();

        // Nominal transaction
        respPio = 32'h0000_0000;
        start_req();
        ack_to_read(1'b0);
        data_after(3, 16'h0015, 1'b0);

        // Ack timeout: ERR entered on the 16th edge after REQ entry
        respPio = 32'h0000_0000;
        start_req();
        repeat (TMO - 1) tick();
        chk_value("ackto_pre_terr", {31'd0, timeoutErr}, 32'd0);
        chk_value("ackto_pre_cmd", cmdPio, REQ_CODE);
        tick();
        chk_value("ackto_terr", {31'd0, timeoutErr}, 32'd1);
        chk_value("ackto_cmd", cmdPio, 32'd0);
        chk_value("ackto_result", {16'd0, result}, 32'h0000_0015);
        tick();
        chk_value("ackto_terr_end", {31'd0, timeoutErr}, 32'd0);
        chk_value("ackto_busy_end", {31'd0, busy}, 32'd0);

        // Data timeout
        respPio = 32'h0000_0000;
        start_req();
        ack_to_read(1'b0);
        repeat (TMO - 1) tick();
        chk_value("datato_pre_terr", {31'd0, timeoutErr}, 32'd0);
        chk_value("datato_pre_cmd", cmdPio, READ_CODE);
        tick();
        chk_value("datato_terr", {31'd0, timeoutErr}, 32'd1);
        chk_value("datato_cmd", cmdPio, 32'd0);
        chk_value("datato_result", {16'd0, result}, 32'h0000_0015);
        tick();
        chk_value("datato_busy_end", {31'd0, busy}, 32'd0);

        // Stale data tag present at start must not advance REQ
        respPio = 32'h0003_ABCD;
        start_req();
        repeat (5) tick();
        chk_value("stale_req_cmd", cmdPio, REQ_CODE);
        chk_value("stale_result", {16'd0, result}, 32'h0000_0015);
        ack_to_read(1'b0);
        data_after(3, 16'h1234, 1'b0);

        // start re-pulsed in HOLD and READ: one done, no restart, no queueing
        respPio = 32'h0000_0000;
        snap = done_cnt;
        start_req();
        ack_to_read(1'b1);
        data_after(3, 16'h00C3, 1'b1);
        chk_value("busy_one_done", done_cnt - snap, 32'd1);
        tick();
        chk_value("busy_no_queue", {31'd0, busy}, 32'd0);

        // Data arriving on the timeout cycle wins (done, not timeoutErr)
        respPio = 32'h0000_0000;
        start_req();
        ack_to_read(1'b0);
        data_after(TMO, 16'hBEEF, 1'b0);

        // Reset while in READ
        respPio = 32'h0000_0000;
        snap = done_cnt;
        start_req();
        ack_to_read(1'b0);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk_value("mrst_cmd", cmdPio, 32'd0);
        chk_value("mrst_busy", {31'd0, busy}, 32'd0);
        chk_value("mrst_done", {31'd0, done}, 32'd0);
        chk_value("mrst_terr", {31'd0, timeoutErr}, 32'd0);
        chk_value("mrst_result", {16'd0, result}, 32'd0);
        tick();
        chk_value("mrst_no_done", done_cnt - snap, 32'd0);
        respPio = 32'h0000_0000;
        start_req();
        ack_to_read(1'b0);
        data_after(3, 16'h5A5A, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
